// File: rtl/eq_window_ctrl.sv
// Windowed nibble-equality counter: counts samples whose high half equals their
// low half over a programmed number of valid samples and reports count/hit/sat.
module eq_window_ctrl #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8,
    parameter int WIN_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WIN_W-1:0]  win_len_i,
    input  logic [CNT_W-1:0]  thresh_i,
    input  logic [DATA_W-1:0] in1_i,
    input  logic              in1_valid_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  result_o,
    output logic              hit_o,
    output logic              sat_o
);

    localparam int HALF_W = DATA_W / 2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIN_W-1:0] remaining;
    logic [CNT_W-1:0] thresh_q;
    logic             sat_run;

    logic             sample_eq;
    logic [CNT_W-1:0] count_next;
    logic             sat_next;

    assign sample_eq = (in1_i[DATA_W-1:HALF_W] == in1_i[HALF_W-1:0]);

    // Counter value after the current sample; a full counter holds and flags saturation.
    always_comb begin
        count_next = count;
        sat_next   = sat_run;
        if (in1_valid_i && sample_eq) begin
            if (&count) begin
                sat_next = 1'b1;
            end else begin
                count_next = count + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            count     <= '0;
            remaining <= '0;
            thresh_q  <= '0;
            sat_run   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            result_o  <= '0;
            hit_o     <= 1'b0;
            sat_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        count   <= '0;
                        sat_run <= 1'b0;
                        if (win_len_i != '0) begin
                            remaining <= win_len_i;
                            thresh_q  <= thresh_i;
                            busy_o    <= 1'b1;
                            state     <= COUNT;
                        end else begin
                            // Empty window reports immediately with a zero count.
                            done_o   <= 1'b1;
                            result_o <= '0;
                            hit_o    <= (thresh_i == '0);
                            sat_o    <= 1'b0;
                            state    <= DONE;
                        end
                    end
                end
                COUNT: begin
                    if (abort_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (in1_valid_i) begin
                        count     <= count_next;
                        sat_run   <= sat_next;
                        remaining <= remaining - WIN_ONE;
                        // The final sample's contribution is folded into the reported result.
                        if (remaining == WIN_ONE) begin
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                            result_o <= count_next;
                            hit_o    <= (count_next >= thresh_q);
                            sat_o    <= sat_next;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_window_ctrl.sv
// Self-checking bench for eq_window_ctrl: directed scenarios plus randomized
// windows compared against a behavioural count-per-window model.
module tb_eq_window_ctrl;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;
    localparam int WIN_W  = 9;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int HALF_MOD = 1 << (DATA_W / 2);

    logic              clk_i       = 1'b0;
    logic              rst_ni      = 1'b0;
    logic              start_i     = 1'b0;
    logic              abort_i     = 1'b0;
    logic [WIN_W-1:0]  win_len_i   = '0;
    logic [CNT_W-1:0]  thresh_i    = '0;
    logic [DATA_W-1:0] in1_i       = '0;
    logic              in1_valid_i = 1'b0;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  result_o;
    logic              hit_o;
    logic              sat_o;

    int checks = 0;
    int errors = 0;

    int exp_result = 0;
    int exp_hit    = 0;
    int exp_sat    = 0;

    int sample_q[$];
    int gap_q[$];

    eq_window_ctrl #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .WIN_W (WIN_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .win_len_i  (win_len_i),
        .thresh_i   (thresh_i),
        .in1_i      (in1_i),
        .in1_valid_i(in1_valid_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .hit_o      (hit_o),
        .sat_o      (sat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int is_equal(input int d);
        return ((d / HALF_MOD) == (d % HALF_MOD)) ? 1 : 0;
    endfunction

    function automatic int equal_value();
        int v;
        v = $urandom_range(0, HALF_MOD - 1);
        return v * HALF_MOD + v;
    endfunction

    task automatic check_state(input string tag, input int busy, input int done);
        check({tag, ".busy"},   {31'd0, busy_o}, busy);
        check({tag, ".done"},   {31'd0, done_o}, done);
        check({tag, ".result"}, {24'd0, result_o}, exp_result);
        check({tag, ".hit"},    {31'd0, hit_o}, exp_hit);
        check({tag, ".sat"},    {31'd0, sat_o}, exp_sat);
    endtask

    task automatic push(input int d, input int g);
        sample_q.push_back(d);
        gap_q.push_back(g);
    endtask

    task automatic clear_queues();
        sample_q.delete();
        gap_q.delete();
    endtask

    // Random start requests and parameter noise while counting must have no effect.
    task automatic poke_noise(input int enable);
        start_i   = enable && ($urandom_range(0, 3) == 0);
        win_len_i = WIN_W'($urandom);
        thresh_i  = CNT_W'($urandom);
    endtask

    task automatic run_window(input string tag, input int len, input int thr, input int noise);
        int eq_total;
        eq_total  = 0;
        start_i   = 1'b1;
        win_len_i = WIN_W'(len);
        thresh_i  = CNT_W'(thr);
        tick();
        start_i = 1'b0;
        if (len > 0) begin
            check({tag, ".busy_after_start"}, {31'd0, busy_o}, 1);
            check({tag, ".no_early_done"}, {31'd0, done_o}, 0);
        end
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                in1_valid_i = 1'b0;
                in1_i       = DATA_W'(equal_value());
                poke_noise(noise);
                tick();
                check({tag, ".gap_done"}, {31'd0, done_o}, 0);
            end
            in1_valid_i = 1'b1;
            in1_i       = DATA_W'(sample_q[i]);
            eq_total   += is_equal(sample_q[i]);
            poke_noise(noise);
            tick();
            if (i < len - 1) begin
                check({tag, ".mid_done"}, {31'd0, done_o}, 0);
            end
        end
        in1_valid_i = 1'b0;
        start_i     = 1'b0;
        exp_result  = (eq_total > CNT_MAX) ? CNT_MAX : eq_total;
        exp_sat     = (eq_total > CNT_MAX) ? 1 : 0;
        exp_hit     = (exp_result >= thr) ? 1 : 0;
        check_state({tag, ".done_cycle"}, 0, 1);
        tick();
        check_state({tag, ".after_done"}, 0, 0);
    endtask

    task automatic run_abort(input string tag, input int len, input int n_before);
        start_i   = 1'b1;
        win_len_i = WIN_W'(len);
        thresh_i  = '0;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < n_before; i++) begin
            in1_valid_i = 1'b1;
            in1_i       = DATA_W'(equal_value());
            tick();
            check_state({tag, ".counting"}, 1, 0);
        end
        abort_i     = 1'b1;
        in1_valid_i = 1'b1;
        in1_i       = DATA_W'(equal_value());
        tick();
        abort_i     = 1'b0;
        in1_valid_i = 1'b0;
        check_state({tag, ".aborted"}, 0, 0);
    endtask

    task automatic applyStimulus();
        int len;
        int thr;

        // Reset held for three cycles, then idle samples without a start.
        rst_ni = 1'b0;
        repeat (3) tick();
        check_state("reset", 0, 0);
        rst_ni = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            in1_valid_i = 1'b1;
            in1_i       = 4'b0101;
            tick();
            check_state("idle_no_start", 0, 0);
        end
        in1_valid_i = 1'b0;

        // Basic back-to-back window.
        clear_queues();
        push(4'b0101, 0); push(4'b0110, 0); push(4'b1111, 0); push(4'b0000, 0);
        run_window("basic", 4, 2, 0);
        check("basic.result_value", {24'd0, result_o}, 3);

        // Idle cycles inside a window are neither counted nor consumed.
        clear_queues();
        push(4'b1010, 0); push(4'b1011, 2); push(4'b0000, 0);
        run_window("gapped", 3, 3, 0);

        // Counter exactly reaches full scale, then overflows.
        clear_queues();
        for (int i = 0; i < 255; i++) push(equal_value(), 0);
        run_window("full_255", 255, 200, 0);
        clear_queues();
        for (int i = 0; i < 300; i++) push(equal_value(), 0);
        run_window("sat_300", 300, 255, 0);

        // Abort keeps previous results, then an immediate restart.
        run_abort("abort", 10, 5);
        clear_queues();
        push(equal_value(), 0); push(equal_value(), 0);
        run_window("restart", 2, 1, 0);

        // Empty windows report at once.
        clear_queues();
        run_window("empty_t0", 0, 0, 0);
        run_window("empty_t5", 0, 5, 0);

        // Minimum window.
        clear_queues();
        push(4'b1001, 0);
        run_window("min_win", 1, 0, 0);

        // Randomized windows with gaps and ignored start requests.
        for (int w = 0; w < 25; w++) begin
            clear_queues();
            len = $urandom_range(1, 40);
            thr = $urandom_range(0, 20);
            for (int i = 0; i < len; i++) begin
                push(($urandom_range(0, 1) == 1) ? equal_value() : int'($urandom_range(0, 15)),
                     $urandom_range(0, 2));
            end
            run_window("random", len, thr, 1);
        end

        // Asynchronous reset in the middle of a window.
        start_i   = 1'b1;
        win_len_i = WIN_W'(10);
        thresh_i  = '0;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in1_valid_i = 1'b1;
            in1_i       = 4'b0000;
            tick();
        end
        check("midreset.busy_before", {31'd0, busy_o}, 1);
        rst_ni = 1'b0;
        #1;
        exp_result = 0;
        exp_hit    = 0;
        exp_sat    = 0;
        check_state("midreset.async", 0, 0);
        in1_valid_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        check_state("midreset.after", 0, 0);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eq_window_ctrl.md
Name: eq_window_ctrl

Overview:
- Windowed controller for the nibble-equality counting datapath: counts the samples whose high half equals their low half over a programmed number of valid samples.
- Reports the final count, a threshold-hit flag and a saturation flag.
- Sequences arm, count and report phases for a host or test sequencer.
- Sits between the sample source (in1 stream) and a status/register interface.

Parameters:
- DATA_W, 4, sample width; must be even; high half = [DATA_W-1:DATA_W/2], low half = [DATA_W/2-1:0]
- CNT_W, 8, equality counter and result width
- WIN_W, 8, window-length width

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  request a new measurement window
- abort_i  in  1  cancel the window in progress
- win_len_i  in  WIN_W  number of valid samples per window; sampled on accepted start
- thresh_i  in  CNT_W  hit threshold; sampled on accepted start
- in1_i  in  DATA_W  sample data
- in1_valid_i  in  1  in1_i carries a sample this cycle
- busy_o  out  1  high in COUNT
- done_o  out  1  one-cycle pulse, window complete
- result_o  out  CNT_W  equality count of the last completed window
- hit_o  out  1  result_o >= threshold of the last completed window
- sat_o  out  1  the last completed window's counter saturated

Behaviour:
- Reset (async, rst_ni low): state=IDLE; internal counter, window remaining count and latched threshold = 0; busy_o=0, done_o=0, result_o=0, hit_o=0, sat_o=0.
- States: IDLE, COUNT, DONE. All outputs are registered.
- IDLE:
  - start_i=1 and win_len_i!=0: latch win_len_i into remaining and thresh_i; clear counter and sat; next state COUNT.
  - start_i=1 and win_len_i==0: clear counter and sat; next state DONE (empty window; result 0, hit = (thresh_i==0)).
  - abort_i is ignored in IDLE.
- COUNT:
  - Each cycle with in1_valid_i=1: remaining decrements by 1.
  - Also, if high half == low half: counter increments by 1. At all-ones, the counter holds and sat sets.
  - The in1_valid_i=0 cycles are neither counted nor consumed.
  - When the cycle consumes the last sample (remaining==1 and valid), the counter update from that sample is included and next state is DONE.
  - abort_i=1 has priority over sample processing: next state IDLE, no done_o, result_o/hit_o/sat_o unchanged.
  - start_i is ignored.
- DONE (exactly one cycle):
  - done_o=1.
  - result_o, hit_o and sat_o take the final values in the same cycle and hold until the next DONE.
  - Next state IDLE. start_i and abort_i are ignored; a new start is accepted from IDLE the following cycle.
- Latency:
  - start accepted at edge k: first sample counted is the one valid in the cycle after edge k.
  - Last valid sample at cycle n: done_o high in cycle n+1.
  - Minimum window (win_len=1, valid every cycle): start to done_o = 2 cycles.
- Width rules:
  - Counter increments are unsigned and saturate; they never wrap.
  - Threshold compare is unsigned >=.
  - remaining is WIN_W bits and never underflows; exit happens at 1.
- Reset mid-operation: immediate return to reset values; any partial window is lost.

Test Plan:
- Reset then idle: rst_ni low 3 cycles -> all outputs 0; with no start, 20 valid samples of in1=4'b0101 -> result_o stays 0, done_o never pulses.
- Basic window: start, win_len=4, thresh=2, samples 4'b0101, 4'b0110, 4'b1111, 4'b0000 valid back-to-back -> done_o pulses 1 cycle after the 4th sample; result_o=3, hit_o=1, sat_o=0.
- Gapped valid: win_len=3, thresh=3, samples 4'b1010 (valid), 2 idle cycles, 4'b1011 (valid), 4'b0000 (valid) -> idle cycles ignored; result_o=2, hit_o=0; done_o one cycle after the 3rd valid sample.
- Saturation: CNT_W=8, win_len=255 then a second window of 300 equal samples using WIN_W=9 -> first window result_o=255 and sat_o=0; second window result_o=255 and sat_o=1.
- Abort and restart: win_len=10, abort_i after 5 equal samples -> no done_o, result_o keeps the previous value; an immediate start with win_len=2 and 2 equal samples -> result_o=2.
- Edge cases:
  - win_len=0 with thresh=0 -> done_o 1 cycle later, result_o=0, hit_o=1.
  - start during COUNT -> ignored.
  - rst_ni pulsed mid-window -> outputs 0 asynchronously.
